// File: rtl/mesi_bus_arbiter.sv
// Snooping-bus arbiter for four MESI caches: round-robin grant, snoop broadcast,
// ack collection with timeout, and a one-cycle completion pulse with merged flags.
module mesi_bus_arbiter #(
  parameter int SNOOP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  req,
  input  logic [7:0]  req_cmd,
  input  logic [79:0] req_addr,
  output logic [3:0]  gnt,
  output logic        snp_valid,
  output logic [1:0]  snp_cmd,
  output logic [19:0] snp_addr,
  output logic [3:0]  snp_target,
  input  logic [3:0]  snp_ack,
  input  logic [3:0]  snp_shared,
  input  logic [3:0]  snp_dirty,
  output logic        done,
  output logic        done_shared,
  output logic        done_dirty,
  output logic        done_err
);

  typedef enum logic [1:0] {IDLE, SNOOP, COLLECT, DONE} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(SNOOP_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [1:0]  last_reg, last_next;
  logic [1:0]  win_reg, win_next;
  logic [3:0]  gnt_reg, gnt_next;
  logic        snp_valid_reg, snp_valid_next;
  logic [1:0]  snp_cmd_reg, snp_cmd_next;
  logic [19:0] snp_addr_reg, snp_addr_next;
  logic [3:0]  snp_target_reg, snp_target_next;
  logic [3:0]  ack_seen_reg, ack_seen_next;
  logic        sh_acc_reg, sh_acc_next;
  logic        dt_acc_reg, dt_acc_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        done_reg, done_next;
  logic        done_sh_reg, done_sh_next;
  logic        done_dt_reg, done_dt_next;
  logic        done_err_reg, done_err_next;

  logic [1:0]  cmd_arr [4];
  logic [19:0] addr_arr [4];

  // Command 11 is folded into BusRd at the source so snp_cmd never carries it.
  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign cmd_arr[gi]  = (req_cmd[2*gi +: 2] == 2'b11) ? 2'b00 : req_cmd[2*gi +: 2];
    assign addr_arr[gi] = req_addr[20*gi +: 20];
  end

  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_reg + k[1:0];
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  logic [3:0] new_ack;
  logic       all_acked;
  logic       sh_any;
  logic       dt_any;

  always_comb begin
    state_next      = state_reg;
    last_next       = last_reg;
    win_next        = win_reg;
    gnt_next        = gnt_reg;
    snp_cmd_next    = snp_cmd_reg;
    snp_addr_next   = snp_addr_reg;
    snp_target_next = snp_target_reg;
    ack_seen_next   = ack_seen_reg;
    sh_acc_next     = sh_acc_reg;
    dt_acc_next     = dt_acc_reg;
    cnt_next        = cnt_reg;
    snp_valid_next  = 1'b0;
    done_next       = 1'b0;
    done_sh_next    = 1'b0;
    done_dt_next    = 1'b0;
    done_err_next   = 1'b0;

    // Only first acks from targeted caches contribute.
    new_ack   = snp_ack & snp_target_reg & ~ack_seen_reg;
    all_acked = ((ack_seen_reg | new_ack) == snp_target_reg);
    sh_any    = sh_acc_reg | (|(snp_shared & new_ack));
    dt_any    = dt_acc_reg | (|(snp_dirty & new_ack));

    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next      = SNOOP;
          win_next        = pick;
          gnt_next        = 4'b0001 << pick;
          snp_target_next = ~(4'b0001 << pick);
          snp_cmd_next    = cmd_arr[pick];
          snp_addr_next   = addr_arr[pick];
          snp_valid_next  = 1'b1;
          ack_seen_next   = '0;
          sh_acc_next     = 1'b0;
          dt_acc_next     = 1'b0;
          cnt_next        = '0;
        end
      end
      SNOOP, COLLECT: begin
        ack_seen_next = ack_seen_reg | new_ack;
        sh_acc_next   = sh_any;
        dt_acc_next   = dt_any;
        if (state_reg == COLLECT) cnt_next = cnt_reg + 8'd1;
        // A complete ack set wins over a simultaneous timeout.
        if (all_acked) begin
          state_next   = DONE;
          done_next    = 1'b1;
          done_sh_next = sh_any;
          done_dt_next = dt_any;
        end else if (state_reg == COLLECT && cnt_reg == TIMEOUT_LAST) begin
          state_next    = DONE;
          done_next     = 1'b1;
          done_err_next = 1'b1;
        end else begin
          state_next = COLLECT;
        end
      end
      DONE: begin
        state_next      = IDLE;
        last_next       = win_reg;
        gnt_next        = '0;
        snp_target_next = '0;
        snp_cmd_next    = '0;
        snp_addr_next   = '0;
        ack_seen_next   = '0;
        sh_acc_next     = 1'b0;
        dt_acc_next     = 1'b0;
        cnt_next        = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      last_reg       <= 2'd3;
      win_reg        <= '0;
      gnt_reg        <= '0;
      snp_valid_reg  <= 1'b0;
      snp_cmd_reg    <= '0;
      snp_addr_reg   <= '0;
      snp_target_reg <= '0;
      ack_seen_reg   <= '0;
      sh_acc_reg     <= 1'b0;
      dt_acc_reg     <= 1'b0;
      cnt_reg        <= '0;
      done_reg       <= 1'b0;
      done_sh_reg    <= 1'b0;
      done_dt_reg    <= 1'b0;
      done_err_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_reg       <= last_next;
      win_reg        <= win_next;
      gnt_reg        <= gnt_next;
      snp_valid_reg  <= snp_valid_next;
      snp_cmd_reg    <= snp_cmd_next;
      snp_addr_reg   <= snp_addr_next;
      snp_target_reg <= snp_target_next;
      ack_seen_reg   <= ack_seen_next;
      sh_acc_reg     <= sh_acc_next;
      dt_acc_reg     <= dt_acc_next;
      cnt_reg        <= cnt_next;
      done_reg       <= done_next;
      done_sh_reg    <= done_sh_next;
      done_dt_reg    <= done_dt_next;
      done_err_reg   <= done_err_next;
    end
  end

  assign gnt         = gnt_reg;
  assign snp_valid   = snp_valid_reg;
  assign snp_cmd     = snp_cmd_reg;
  assign snp_addr    = snp_addr_reg;
  assign snp_target  = snp_target_reg;
  assign done        = done_reg;
  assign done_shared = done_sh_reg;
  assign done_dirty  = done_dt_reg;
  assign done_err    = done_err_reg;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// Randomized bench for mesi_bus_arbiter: per-transaction ack schedules are scored
// against a transaction-level model of arbitration, completion time and flags.
module tb_mesi_bus_arbiter;
  localparam int TO    = 16;
  localparam int NEVER = 99;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  req_cmd = '0;
  logic [79:0] req_addr = '0;
  logic [3:0]  gnt;
  logic        snp_valid;
  logic [1:0]  snp_cmd;
  logic [19:0] snp_addr;
  logic [3:0]  snp_target;
  logic [3:0]  snp_ack = '0;
  logic [3:0]  snp_shared = '0;
  logic [3:0]  snp_dirty = '0;
  logic        done;
  logic        done_shared;
  logic        done_dirty;
  logic        done_err;

  always #5 clk = ~clk;

  mesi_bus_arbiter #(.SNOOP_TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
    .gnt(gnt), .snp_valid(snp_valid), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
    .snp_target(snp_target), .snp_ack(snp_ack), .snp_shared(snp_shared),
    .snp_dirty(snp_dirty), .done(done), .done_shared(done_shared),
    .done_dirty(done_dirty), .done_err(done_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Model state and per-transaction ack schedule (offset 0 = SNOOP cycle).
  int m_last  = 3;
  bit at_done = 1'b0;
  int txn_no  = 0;
  int ack_dly [4];
  bit ack_sh  [4];
  bit ack_dt  [4];
  bit ack_dup [4];
  int own_off   = -1;
  int abort_off = 0;

  task automatic set_sched(input int d0, input int d1, input int d2, input int d3,
                           input logic [3:0] sh, input logic [3:0] dt);
    ack_dly[0] = d0; ack_dly[1] = d1; ack_dly[2] = d2; ack_dly[3] = d3;
    for (int i = 0; i < 4; i++) begin
      ack_sh[i]  = sh[i];
      ack_dt[i]  = dt[i];
      ack_dup[i] = 1'b0;
    end
    own_off   = -1;
    abort_off = 0;
  endtask

  task automatic rand_sched();
    for (int i = 0; i < 4; i++) begin
      case ($urandom_range(0, 9))
        0:       ack_dly[i] = NEVER;
        1:       ack_dly[i] = $urandom_range(6, TO);
        default: ack_dly[i] = $urandom_range(0, 4);
      endcase
      ack_sh[i]  = 1'($urandom);
      ack_dt[i]  = 1'($urandom);
      ack_dup[i] = 1'($urandom);
    end
    own_off   = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(0, 3);
    abort_off = 0;
  endtask

  task automatic do_reset();
    req = '0;
    snp_ack = '0;
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    m_last  = 3;
    at_done = 1'b0;
  endtask

  task automatic idle_gap();
    req = '0;
    @(negedge clk);
    chk("idle_gnt", gnt, 4'h0);
    chk("idle_valid", snp_valid, 1'b0);
    chk("idle_done", done, 1'b0);
    at_done = 1'b0;
  endtask

  task automatic txn(input logic [3:0] r, input logic [7:0] cv, input logic [79:0] av);
    int w, lat, maxd, done_off, exp_lat;
    logic [3:0]  tgt;
    logic [1:0]  e_cmd;
    logic [19:0] e_addr;
    bit e_sh, e_dt, e_err, finished;

    exp_lat  = at_done ? 2 : 1;
    req      = r;
    req_cmd  = cv;
    req_addr = av;

    // Round-robin: first requester after the previous owner.
    w = -1;
    for (int k = 1; k <= 4; k++)
      if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
    tgt    = 4'hF & ~(4'b0001 << w);
    e_cmd  = cv[2*w +: 2];
    if (e_cmd == 2'b11) e_cmd = 2'b00;
    e_addr = av[20*w +: 20];

    maxd = 0; e_sh = 1'b0; e_dt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i != w) begin
        if (ack_dly[i] > maxd) maxd = ack_dly[i];
        e_sh |= ack_sh[i];
        e_dt |= ack_dt[i];
      end
    end
    if (maxd <= TO) begin
      done_off = maxd + 1;
      e_err    = 1'b0;
    end else begin
      done_off = TO + 1;
      e_err    = 1'b1;
      e_sh     = 1'b0;
      e_dt     = 1'b0;
    end

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!snp_valid && lat < 8);
    chk("snoop_latency", lat, exp_lat);
    chk("snoop_gnt", gnt, 4'b0001 << w);
    chk("snoop_target", snp_target, tgt);
    chk("snoop_cmd", snp_cmd, e_cmd);
    chk("snoop_addr", snp_addr, e_addr);

    // Request side changes after latching must have no effect.
    req      = 4'($urandom);
    req_cmd  = 8'($urandom);
    req_addr = {16'($urandom), 32'($urandom), 32'($urandom)};

    finished = 1'b0;
    for (int off = 0; off <= TO + 3 && !finished; off++) begin
      if (off > 0) begin
        if (abort_off == off) begin
          rstn = 1'b0;
          #1;
          chk("rst_gnt", gnt, 4'h0);
          chk("rst_target", snp_target, 4'h0);
          chk("rst_cmd", snp_cmd, 2'b00);
          chk("rst_addr", snp_addr, 20'h0);
          chk("rst_done", done, 1'b0);
          snp_ack = '0;
          for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_no_done", done, 1'b0);
          end
          req  = 4'hF;
          rstn = 1'b1;
          #1;
          chk("rst_release_gnt", gnt, 4'h0);
          chk("rst_release_valid", snp_valid, 1'b0);
          m_last   = 3;
          at_done  = 1'b0;
          finished = 1'b1;
        end else if (off == done_off) begin
          chk("done_pulse", done, 1'b1);
          chk("done_shared", done_shared, e_sh);
          chk("done_dirty", done_dirty, e_dt);
          chk("done_err", done_err, e_err);
          chk("done_gnt_hold", gnt, 4'b0001 << w);
          chk("done_target_hold", snp_target, tgt);
          chk("done_cmd_hold", snp_cmd, e_cmd);
          chk("done_valid_low", snp_valid, 1'b0);
          m_last   = w;
          at_done  = 1'b1;
          finished = 1'b1;
        end else begin
          chk("done_early", done, 1'b0);
          chk("collect_valid_low", snp_valid, 1'b0);
          chk("collect_gnt_hold", gnt, 4'b0001 << w);
        end
      end
      if (!finished) begin
        snp_ack    = '0;
        snp_shared = 4'($urandom);
        snp_dirty  = 4'($urandom);
        for (int i = 0; i < 4; i++) begin
          if (i == w) begin
            if (off == own_off) snp_ack[i] = 1'b1;
          end else if (ack_dly[i] == off) begin
            snp_ack[i]    = 1'b1;
            snp_shared[i] = ack_sh[i];
            snp_dirty[i]  = ack_dt[i];
          end else if (ack_dup[i] && ack_dly[i] + 1 == off) begin
            snp_ack[i] = 1'b1;
          end
        end
        @(negedge clk);
      end
    end
    snp_ack    = '0;
    snp_shared = '0;
    snp_dirty  = '0;
    txn_no++;
    $display("[TB] txn %0d req=%b winner=%0d cmd=%0d addr=%05h done_off=%0d sh=%0b dt=%0b err=%0b abort=%0d",
             txn_no, r, w, e_cmd, e_addr, done_off, e_sh, e_dt, e_err, abort_off);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_gnt", gnt, 4'h0);
    chk("reset_valid", snp_valid, 1'b0);
    chk("reset_target", snp_target, 4'h0);
    chk("reset_addr", snp_addr, 20'h0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", done_err, 1'b0);
    rstn = 1'b1;

    // Basic read from cache 0, all acks in the SNOOP cycle.
    set_sched(0, 0, 0, 0, 4'h0, 4'h0);
    txn(4'b0001, 8'h00, 80'h12345);

    // Continuous full request: grants rotate 0,1,2,3,0.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_sched($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), 4'($urandom), 4'($urandom));
      txn(4'hF, 8'($urandom), {16'($urandom), 32'($urandom), 32'($urandom)});
      chk("rr_order", m_last, k % 4);
    end

    // Cache 2 owner; staggered acks, owner's own ack ignored.
    set_sched(0, 2, NEVER, 3, 4'b0001, 4'b0010);
    own_off = 1;
    txn(4'b0100, 8'($urandom), {16'($urandom), 32'($urandom), 32'($urandom)});

    // Cache 3 never acks: timeout.
    set_sched(0, 0, 0, NEVER, 4'hF, 4'hF);
    txn(4'b0001, 8'($urandom), {16'($urandom), 32'($urandom), 32'($urandom)});

    // Last ack coincides with the timeout cycle.
    set_sched(3, 0, TO, 0, 4'b0100, 4'b0000);
    txn(4'b0010, 8'($urandom), {16'($urandom), 32'($urandom), 32'($urandom)});

    // Reset in COLLECT, then cache 0 must win first.
    set_sched(0, 0, NEVER, 0, 4'h0, 4'h0);
    abort_off = 5;
    txn(4'b0100, 8'($urandom), {16'($urandom), 32'($urandom), 32'($urandom)});
    set_sched(0, 0, 0, 0, 4'h0, 4'h0);
    txn(4'hF, 8'($urandom), {16'($urandom), 32'($urandom), 32'($urandom)});

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) idle_gap();
      rand_sched();
      txn(4'($urandom_range(1, 15)), 8'($urandom),
          {16'($urandom), 32'($urandom), 32'($urandom)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mesi_bus_arbiter.md
MESI_BUS_ARBITER -- requirements
Module: mesi_bus_arbiter

Interface
REQ-001 The block SHALL have parameter SNOOP_TIMEOUT, default 16, giving the maximum COLLECT cycles before a transaction is aborted (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-cache bus request; bit i belongs to cache i.
REQ-005 req_cmd  input  8  2 bits per cache, [2i+1:2i]: 00 BusRd, 01 BusRdX, 10 BusUpgr, 11 is treated as BusRd.
REQ-006 req_addr  input  80  20-bit block address per cache, [20i+19:20i].
REQ-007 gnt  output  4  one-hot grant to the owning cache.
REQ-008 snp_valid  output  1  one-cycle snoop broadcast strobe.
REQ-009 snp_cmd  output  2  latched command of the granted cache.
REQ-010 snp_addr  output  20  latched address of the granted cache.
REQ-011 snp_target  output  4  caches that must answer, which is all caches except the granted one.
REQ-012 snp_ack  input  4  per-cache snoop response strobe.
REQ-013 snp_shared  input  4  the cache holds the line; valid with snp_ack.
REQ-014 snp_dirty  input  4  the cache holds the line in M and flushes it; valid with snp_ack.
REQ-015 done  output  1  one-cycle transaction completion pulse.
REQ-016 done_shared, done_dirty, done_err  output  1 each  result flags, valid only while done=1.

Function
REQ-017 The FSM SHALL have the states IDLE, SNOOP, COLLECT and DONE, with exactly one transaction in flight at a time.
REQ-018 In IDLE with req!=0, the block SHALL choose a winner by round-robin search starting at (last+1) mod 4, latch its cmd and addr, and enter SNOOP on the next edge.
REQ-019 SNOOP SHALL last exactly one cycle, with gnt equal to the winner's one-hot, snp_valid=1, snp_target=~gnt, and snp_cmd/snp_addr equal to the latched values.
REQ-020 gnt, snp_target, snp_cmd and snp_addr SHALL hold from SNOOP through DONE inclusive; snp_valid SHALL be 0 outside SNOOP.
REQ-021 In both SNOOP and COLLECT, snp_ack bits SHALL be sampled into ack_seen, and shared/dirty OR-accumulated, for targeted caches only; acks from non-targeted caches and repeated acks SHALL be ignored.
REQ-022 When (ack_seen | new acks) equals snp_target, the FSM SHALL enter DONE on the next edge, with done_shared = OR of the collected shared bits and done_dirty = OR of the collected dirty bits.
REQ-023 The timeout counter SHALL clear on SNOOP entry and increment each COLLECT cycle; if it reaches SNOOP_TIMEOUT without all acks, the FSM SHALL enter DONE with done_err=1 and done_shared=done_dirty=0.
REQ-024 If all acks and the timeout occur in the same cycle, the all-acks completion SHALL take precedence and done_err SHALL be 0.
REQ-025 DONE SHALL last one cycle with done=1; it SHALL set last to the winner index, clear gnt, ack_seen and flags, and return to IDLE.
REQ-026 Deassertion of the owner's req after grant SHALL NOT abort the transaction, and the block SHALL ignore changes to req_cmd/req_addr after latching.
REQ-027 A req still asserted in IDLE after DONE SHALL re-arbitrate normally, with round-robin ensuring the other pending requesters are served first.
REQ-028 Latency: req seen in IDLE at cycle N gives snp_valid at N+1 and, with all acks at N+1, done at N+2; IDLE is at N+3 and the earliest next snp_valid is at N+4.

Reset
REQ-029 rstn=0 SHALL immediately force IDLE, gnt=0, snp_valid=0, snp_cmd=0, snp_addr=0, snp_target=0, done and all done_* flags to 0, ack_seen=0, counter=0, and last=3 so cache 0 has first priority.
REQ-030 Reset asserted mid-transaction SHALL discard the transaction without a done pulse, and after rstn rises no output SHALL change before the first clock edge.

Verification
REQ-031 After reset, req=0001, cmd BusRd, addr 0x12345, with caches 1-3 all acking in the SNOOP cycle -> gnt=0001, snp_target=1110, done at N+2, shared=0, dirty=0, err=0.
REQ-032 req=1111 held continuously -> grants in order 0,1,2,3,0, with exactly one done per grant.
REQ-033 Cache 2 owns the bus; cache 0 acks with shared=1, cache 1 acks with dirty=1 two cycles later, cache 3 acks next, and cache 2 also acks -> done_shared=1, done_dirty=1, and cache 2's ack is ignored.
REQ-034 With SNOOP_TIMEOUT=16, cache 3 never acks -> done at COLLECT cycle 16 with err=1, shared=0, dirty=0.
REQ-035 rstn pulsed low during COLLECT -> outputs zero asynchronously, no done pulse, and the next grant goes to cache 0 if requesting.
REQ-036 The final ack and the timeout arrive in the same cycle -> done_err=0, with flags reflecting the collected acks.
